// File: rtl/load_store_unit.sv
// load_store_unit -- byte-serial initiator for the core's data-memory port.
//
// Takes one load/store at a time from execute and walks it over the byte-wide
// data memory as N little-endian beats (N = 1/2/4 by mem_type). Loads are
// assembled and sign/zero-extended, stores are split into bytes. Illegal
// mem_type codes complete immediately with rsp_err and no memory traffic.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata, req_mem_type   request payload
//   rsp_valid                   one-cycle completion pulse
//   rsp_rdata, rsp_err          response payload, held until next response
//   mem_addr, mem_wdata         registered beat address / store byte
//   mem_we, mem_re              registered byte strobes
//   mem_rdata                   read byte, valid the cycle after mem_re
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_mem_type,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  localparam logic [2:0] MT_BS = 3'b000, MT_HS = 3'b001, MT_W = 3'b010,
                         MT_BU = 3'b100, MT_HU = 3'b110;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] wdata;
    logic [2:0]  mtype;
    logic [1:0]  last;   // index of final beat (N-1)
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q;
  logic [1:0]        beat_q, beat_d;   // beat currently on the mem_* outputs
  logic [1:0]        cap_q, cap_d;     // next assembly byte to fill
  logic [31:0]       asm_q, asm_d;
  // [0] mirrors mem_re (issue), [1] marks the cycle mem_rdata holds that byte
  logic [1:0]        vld_pipe;

  logic              accept, in_legal;
  logic [1:0]        in_last;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;
  logic              mem_we_d, mem_re_d;
  logic [31:0]       rsp_rdata_d;
  logic              rsp_err_d;

  function automatic logic [31:0] extend(input logic [31:0] a, input logic [2:0] t);
    case (t)
      MT_BS:   return {{24{a[7]}}, a[7:0]};
      MT_BU:   return {24'h0, a[7:0]};
      MT_HS:   return {{16{a[15]}}, a[15:0]};
      MT_HU:   return {16'h0, a[15:0]};
      MT_W:    return a;
      default: return 32'h0;
    endcase
  endfunction

  assign req_ready = rst_n && (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    in_legal = 1'b1;
    in_last  = 2'd0;
    case (req_mem_type)
      MT_BS, MT_BU: in_last = 2'd0;
      MT_HS, MT_HU: in_last = 2'd1;
      MT_W:         in_last = 2'd3;
      default:      in_legal = 1'b0;
    endcase
  end

  // Load bytes land one cycle behind their read strobe.
  always_comb begin
    asm_d = asm_q;
    if (vld_pipe[1]) begin
      case (cap_q)
        2'd0:    asm_d[7:0]   = mem_rdata;
        2'd1:    asm_d[15:8]  = mem_rdata;
        2'd2:    asm_d[23:16] = mem_rdata;
        default: asm_d[31:24] = mem_rdata;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = in_legal ? XFER : RESP;
      XFER:  if (beat_q == req_q.last) state_d = req_q.we ? RESP : DRAIN;
      DRAIN: state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: next values of the registered strobes/address/response
  always_comb begin
    mem_addr_d  = mem_addr;
    mem_wdata_d = 8'h0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    beat_d      = beat_q;
    cap_d       = vld_pipe[1] ? cap_q + 2'd1 : cap_q;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    case (state_q)
      IDLE: if (accept && in_legal) begin
        beat_d      = 2'd0;
        cap_d       = 2'd0;
        mem_addr_d  = req_addr;
        mem_wdata_d = req_we ? req_wdata[7:0] : 8'h0;
        mem_we_d    = req_we;
        mem_re_d    = !req_we;
      end
      XFER: if (beat_q != req_q.last) begin
        beat_d      = beat_q + 2'd1;
        mem_addr_d  = mem_addr + ADDR_ONE;
        mem_wdata_d = req_q.we ? 8'(req_q.wdata >> {beat_d, 3'b000}) : 8'h0;
        mem_we_d    = req_q.we;
        mem_re_d    = !req_q.we;
      end
      default: ;
    endcase
    if (state_d == RESP) begin
      // Only an illegal request jumps straight from IDLE to RESP.
      rsp_err_d   = (state_q == IDLE);
      rsp_rdata_d = (state_q == DRAIN) ? extend(asm_d, req_q.mtype) : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      beat_q    <= 2'd0;
      cap_q     <= 2'd0;
      asm_q     <= 32'h0;
      vld_pipe  <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= 8'h0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept)
        req_q <= '{we: req_we, wdata: req_wdata, mtype: req_mem_type, last: in_last};
      beat_q    <= beat_d;
      cap_q     <= cap_d;
      asm_q     <= asm_d;
      vld_pipe  <= {vld_pipe[0], mem_re_d};
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_we    <= mem_we_d;
      mem_re    <= mem_re_d;
      rsp_valid <= (state_d == RESP);
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-memory model, per-cycle
// expectation queue built from the access rules, directed and random traffic.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_mem_type = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata = 8'h0;
  logic        mem_we, mem_re;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mem_type(req_mem_type),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Physical memory (driven by the DUT) and reference memory (driven by model)
  logic [7:0] pmem [logic [31:0]];
  logic [7:0] rmem [logic [31:0]];

  function automatic logic [7:0] prd(input logic [31:0] a);
    return pmem.exists(a) ? pmem[a] : 8'h00;
  endfunction
  function automatic logic [7:0] rrd(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : 8'h00;
  endfunction
  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    pmem[a] = v; rmem[a] = v;
  endtask

  // Memory responder: read byte presented for the cycle after mem_re.
  bit         rd_pend = 0;
  logic [7:0] rd_val;
  always @(negedge clk) begin
    if (rst_n && mem_we) pmem[mem_addr] = mem_wdata;
    if (rst_n && mem_re) begin rd_pend = 1; rd_val = prd(mem_addr); end
  end
  always @(posedge clk) begin
    #1;
    mem_rdata = rd_pend ? rd_val : 8'($urandom);
    rd_pend = 0;
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        we, re;
    logic [31:0] addr;
    logic [7:0]  wd;
    logic        rv, err;
    logic [31:0] rd;
  } exp_t;
  exp_t q[$];
  logic [31:0] last_rd = 0;
  logic        last_err = 0;

  function automatic logic [31:0] ext(input logic [2:0] t, input logic [31:0] a);
    logic [31:0]        w;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    int                 v;
    w  = {rrd(a + 32'd3), rrd(a + 32'd2), rrd(a + 32'd1), rrd(a)};
    sb = w[7:0];
    sh = w[15:0];
    case (t)
      3'b000: begin v = sb; return v; end
      3'b001: begin v = sh; return v; end
      3'b100: return w & 32'hFF;
      3'b110: return w & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  // Every cycle after the accept edge, in order, until the response.
  function automatic void schedule(input bit we, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [2:0] t);
    exp_t e;
    int   n;
    case (t)
      3'b000, 3'b100: n = 1;
      3'b001, 3'b110: n = 2;
      3'b010:         n = 4;
      default:        n = 0;
    endcase
    e = '{default: 0};
    if (n == 0) begin
      e.rv = 1; e.err = 1; e.rd = 0;
      q.push_back(e);
      return;
    end
    for (int k = 0; k < n; k++) begin
      e = '{default: 0};
      e.we = we; e.re = !we; e.addr = a + 32'(k);
      e.wd = 8'(wd >> (8 * k));
      q.push_back(e);
    end
    if (!we) begin e = '{default: 0}; q.push_back(e); end
    e = '{default: 0};
    e.rv = 1; e.rd = we ? 32'h0 : ext(t, a);
    q.push_back(e);
  endfunction

  // One compare per cycle against the model.
  always @(negedge clk) begin
    exp_t e;
    bit   busy;
    if (!rst_n) begin
      q.delete();
      last_rd = 0; last_err = 0;
      chk("rst req_ready", req_ready, 0);
      chk("rst strobes", {rsp_valid, rsp_err, mem_we, mem_re}, 0);
      chk("rst rsp_rdata", rsp_rdata, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_wdata", mem_wdata, 0);
    end else begin
      busy = (q.size() != 0);
      e = '{default: 0};
      if (busy) e = q.pop_front();
      chk("req_ready", req_ready, !busy);
      chk("mem_we", mem_we, e.we);
      chk("mem_re", mem_re, e.re);
      if (e.we || e.re) chk("mem_addr", mem_addr, e.addr);
      if (e.we) begin
        chk("mem_wdata", mem_wdata, e.wd);
        rmem[e.addr] = e.wd;
      end
      chk("rsp_valid", rsp_valid, e.rv);
      if (e.rv) begin last_rd = e.rd; last_err = e.err; end
      chk("rsp_rdata", rsp_rdata, last_rd);
      chk("rsp_err", rsp_err, last_err);
      if (!busy && req_valid) schedule(req_we, req_addr, req_wdata, req_mem_type);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_req(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] t, output logic [31:0] rd,
                         output logic err, output int lat);
    int w;
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_mem_type = t;
    w = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      if (++w > 50) begin chk("accept timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
    req_valid = 0; req_we = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_mem_type = 3'($urandom);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
      if (lat > 20) begin chk("rsp timeout", 1, 0); break; end
    end
    rd = rsp_rdata; err = rsp_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat, acc, rsp;

    for (int i = 0; i < 32; i++) begin
      poke(32'(i), 8'($urandom));
      poke(32'hFFFF_FFE0 + 32'(i), 8'($urandom));
    end

    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // word store then load
    run_req(1, 32'h4, 32'hDEADBEEF, 3'b010, rd, err, lat);
    chk("st word lat", lat, 5);
    chk("st word bytes", {prd(7), prd(6), prd(5), prd(4)}, 32'hDEADBEEF);
    chk("st word rdata", rd, 0);
    run_req(0, 32'h4, 32'h0, 3'b010, rd, err, lat);
    chk("ld word lat", lat, 6);
    chk("ld word rdata", rd, 32'hDEADBEEF);

    // signed / unsigned byte
    poke(32'h2, 8'h80);
    run_req(0, 32'h2, 32'h0, 3'b000, rd, err, lat);
    chk("ld sbyte lat", lat, 3);
    chk("ld sbyte rdata", rd, 32'hFFFFFF80);
    run_req(0, 32'h2, 32'h0, 3'b100, rd, err, lat);
    chk("ld ubyte lat", lat, 3);
    chk("ld ubyte rdata", rd, 32'h00000080);

    // halfword across address wrap
    poke(32'hFFFF_FFFF, 8'h34);
    poke(32'h0, 8'h92);
    run_req(0, 32'hFFFF_FFFF, 32'h0, 3'b001, rd, err, lat);
    chk("ld shalf lat", lat, 4);
    chk("ld shalf rdata", rd, 32'hFFFF9234);
    run_req(0, 32'hFFFF_FFFF, 32'h0, 3'b110, rd, err, lat);
    chk("ld uhalf rdata", rd, 32'h00009234);

    // illegal type, then a legal request clears rsp_err
    run_req(1, 32'h8, 32'h12345678, 3'b011, rd, err, lat);
    chk("illegal lat", lat, 1);
    chk("illegal err", err, 1);
    chk("illegal rdata", rd, 0);
    run_req(0, 32'h2, 32'h0, 3'b100, rd, err, lat);
    chk("post-illegal err", err, 0);
    chk("post-illegal rdata", rd, 32'h80);

    // handshake: valid held high, payload changing every cycle
    acc = 0; rsp = 0;
    @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      #1;
      req_valid = 1; req_we = 1; req_addr = 32'($urandom_range(16, 31));
      req_wdata = $urandom; req_mem_type = $urandom_range(0, 1) ? 3'b000 : 3'b100;
      @(negedge clk);
      if (req_ready) acc++;
      if (rsp_valid) rsp++;
      @(posedge clk);
    end
    #1 req_valid = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) rsp++; end
    chk("hs accepts", acc, 10);
    chk("hs responses", rsp, acc);

    // reset during beat 2 of a word store
    @(posedge clk); #1;
    req_valid = 1; req_we = 1; req_addr = 32'h10; req_wdata = 32'h11223344;
    req_mem_type = 3'b010;
    @(posedge clk); #1 req_valid = 0;      // accepted at this edge
    @(posedge clk);
    @(posedge clk); #1;
    chk("beat2 mem_we", mem_we, 1);
    chk("beat2 mem_addr", mem_addr, 32'h12);
    #1 rst_n = 0;
    #1 chk("abort mem_we", mem_we, 0);
    rsp = 0;
    repeat (2) begin @(negedge clk); if (rsp_valid) rsp++; end
    @(posedge clk); #1 rst_n = 1;
    repeat (4) begin @(negedge clk); if (rsp_valid) rsp++; end
    chk("abort no rsp", rsp, 0);
    chk("post-rst ready", req_ready, 1);
    run_req(0, 32'h10, 32'h0, 3'b110, rd, err, lat);
    chk("post-rst ld lat", lat, 4);
    chk("post-rst ld rdata", rd, 32'h00003344);

    // random traffic
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, 1) ? 32'($urandom_range(0, 31))
                               : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_req(1'($urandom), a, $urandom, 3'($urandom), rd, err, lat);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
